// File: rtl/triangle_channel.sv
// Triangle channel: timer-clocked sequencer gated by linear and length counters, registered ramp output.
// Optional ULTRASONIC_MUTE_EN: periods below 2 hold tri_out at the mid level.
module triangle_channel #(
    parameter int unsigned TIMER_W  = 11,
    parameter int unsigned SEQ_BITS = 5,
    parameter int unsigned LIN_W    = 7,
    parameter int unsigned LEN_W    = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  timer_tick,
    input  logic                  enable_240hz,
    input  logic                  enable_120hz,
    input  logic                  channel_en,
    input  logic                  linear_control,
    input  logic [LIN_W-1:0]      linear_preset,
    input  logic [TIMER_W-1:0]    period,
    input  logic [4:0]            length_select,
    input  logic                  wr_period_hi,
    output logic [SEQ_BITS-2:0]   tri_out,
    output logic                  length_active
);

`ifdef ULTRASONIC_MUTE_EN
    localparam logic [SEQ_BITS-2:0] MUTE_LEVEL = (SEQ_BITS-1)'(1) << (SEQ_BITS-2);
`endif

    logic [TIMER_W-1:0]  timer_cnt;
    logic [SEQ_BITS-1:0] seq;
    logic [LIN_W-1:0]    lin_cnt;
    logic [LEN_W-1:0]    len_cnt;
    logic [LEN_W-1:0]    len_next;
    logic                reload_flag;
    logic                step;
    logic [SEQ_BITS-2:0] ramp;

    function automatic logic [7:0] length_lut(input logic [4:0] idx);
        case (idx)
            5'd0:  length_lut = 8'h0A;  5'd1:  length_lut = 8'hFE;
            5'd2:  length_lut = 8'h14;  5'd3:  length_lut = 8'h02;
            5'd4:  length_lut = 8'h28;  5'd5:  length_lut = 8'h04;
            5'd6:  length_lut = 8'h50;  5'd7:  length_lut = 8'h06;
            5'd8:  length_lut = 8'hA0;  5'd9:  length_lut = 8'h08;
            5'd10: length_lut = 8'h3C;  5'd11: length_lut = 8'h0A;
            5'd12: length_lut = 8'h0E;  5'd13: length_lut = 8'h0C;
            5'd14: length_lut = 8'h1A;  5'd15: length_lut = 8'h0E;
            5'd16: length_lut = 8'h0C;  5'd17: length_lut = 8'h10;
            5'd18: length_lut = 8'h18;  5'd19: length_lut = 8'h12;
            5'd20: length_lut = 8'h30;  5'd21: length_lut = 8'h14;
            5'd22: length_lut = 8'h60;  5'd23: length_lut = 8'h16;
            5'd24: length_lut = 8'hC0;  5'd25: length_lut = 8'h18;
            5'd26: length_lut = 8'h48;  5'd27: length_lut = 8'h1A;
            5'd28: length_lut = 8'h10;  5'd29: length_lut = 8'h1C;
            5'd30: length_lut = 8'h20;  default: length_lut = 8'h1E;
        endcase
    endfunction

    always_comb begin
        step = timer_tick && (timer_cnt == '0);
        ramp = seq[SEQ_BITS-1] ? seq[SEQ_BITS-2:0] : ~seq[SEQ_BITS-2:0];
    end

    // Load beats the half-frame decrement; a disabled channel overrides both.
    always_comb begin
        len_next = len_cnt;
        if (!channel_en)
            len_next = '0;
        else if (wr_period_hi)
            len_next = LEN_W'(length_lut(length_select));
        else if (enable_120hz && !linear_control && (len_cnt != '0))
            len_next = len_cnt - LEN_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            timer_cnt     <= '0;
            seq           <= '0;
            lin_cnt       <= '0;
            len_cnt       <= '0;
            reload_flag   <= 1'b0;
            tri_out       <= '0;
            length_active <= 1'b0;
        end else begin
            if (timer_tick)
                timer_cnt <= (timer_cnt == '0) ? period : timer_cnt - TIMER_W'(1);

            if (step && (lin_cnt != '0) && (len_cnt != '0))
                seq <= seq + SEQ_BITS'(1);

            // Counter action sees the flag value from before this cycle's write.
            if (enable_240hz) begin
                if (reload_flag)
                    lin_cnt <= linear_preset;
                else if (lin_cnt != '0)
                    lin_cnt <= lin_cnt - LIN_W'(1);
            end

            if (wr_period_hi)
                reload_flag <= 1'b1;
            else if (enable_240hz && !linear_control)
                reload_flag <= 1'b0;

            len_cnt       <= len_next;
            length_active <= (len_next != '0);

`ifdef ULTRASONIC_MUTE_EN
            tri_out <= (period < TIMER_W'(2)) ? MUTE_LEVEL : ramp;
`else
            tri_out <= ramp;
`endif
        end
    end

endmodule

// File: tb/tb_triangle_channel.sv
// Self-checking bench for triangle_channel against a cycle-level behavioural model.
module tb_triangle_channel;

    localparam int TIMER_W  = 11;
    localparam int SEQ_BITS = 5;
    localparam int LIN_W    = 7;
    localparam int LEN_W    = 8;
    localparam int STEPS    = 2 ** SEQ_BITS;
    localparam int HALF     = 2 ** (SEQ_BITS - 1);
    localparam int MID      = 2 ** (SEQ_BITS - 2);

    logic                clk = 1'b0;
    logic                rst_n;
    logic                timer_tick;
    logic                enable_240hz;
    logic                enable_120hz;
    logic                channel_en;
    logic                linear_control;
    logic [LIN_W-1:0]    linear_preset;
    logic [TIMER_W-1:0]  period;
    logic [4:0]          length_select;
    logic                wr_period_hi;
    logic [SEQ_BITS-2:0] tri_out;
    logic                length_active;

    int errors = 0;
    int checks = 0;

    int len_table[32] = '{10, 254, 20, 2, 40, 4, 80, 6, 160, 8, 60, 10, 14, 12, 26, 14,
                          12, 16, 24, 18, 48, 20, 96, 22, 192, 24, 72, 26, 16, 28, 32, 30};

    // Model state
    int m_timer, m_seq, m_lin, m_len, m_flag, m_tri, m_act;

    triangle_channel #(
        .TIMER_W(TIMER_W), .SEQ_BITS(SEQ_BITS), .LIN_W(LIN_W), .LEN_W(LEN_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .timer_tick(timer_tick),
        .enable_240hz(enable_240hz), .enable_120hz(enable_120hz),
        .channel_en(channel_en), .linear_control(linear_control),
        .linear_preset(linear_preset), .period(period),
        .length_select(length_select), .wr_period_hi(wr_period_hi),
        .tri_out(tri_out), .length_active(length_active)
    );

    always #5 clk = ~clk;

    function automatic int ramp_of(input int s);
        return (s < HALF) ? (HALF - 1 - s) : (s - HALF);
    endfunction

    // Advance model and DUT by one clock with the currently driven inputs.
    task automatic cyc();
        int n_timer, n_seq, n_lin, n_len, n_flag, n_tri;
        bit stp;
        stp     = timer_tick && (m_timer == 0);
        n_timer = timer_tick ? ((m_timer == 0) ? int'(period) : m_timer - 1) : m_timer;
        n_seq   = (stp && m_lin != 0 && m_len != 0) ? (m_seq + 1) % STEPS : m_seq;
        n_tri   = ramp_of(m_seq);
`ifdef ULTRASONIC_MUTE_EN
        if (period < 2) n_tri = MID;
`endif
        n_lin = m_lin;
        if (enable_240hz) begin
            if (m_flag != 0) n_lin = int'(linear_preset);
            else if (m_lin != 0) n_lin = m_lin - 1;
        end
        n_flag = m_flag;
        if (enable_240hz && !linear_control) n_flag = 0;
        if (wr_period_hi) n_flag = 1;
        n_len = m_len;
        if (!channel_en) n_len = 0;
        else if (wr_period_hi) n_len = len_table[length_select];
        else if (enable_120hz && !linear_control && m_len > 0) n_len = m_len - 1;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            m_timer = 0; m_seq = 0; m_lin = 0; m_len = 0; m_flag = 0; m_tri = 0; m_act = 0;
        end else begin
            m_timer = n_timer; m_seq = n_seq; m_lin = n_lin; m_len = n_len;
            m_flag = n_flag; m_tri = n_tri; m_act = (n_len != 0);
        end
    endtask

    task automatic idle_inputs();
        timer_tick = 0; enable_240hz = 0; enable_120hz = 0; wr_period_hi = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; idle_inputs(); channel_en = 1; linear_control = 0;
        linear_preset = '0; period = 11'd3; length_select = '0;
        cyc(); cyc();
        checks++;
        if (tri_out !== '0) begin errors++; $display("FAIL reset_tri: got %0h want 0", tri_out); end
        checks++;
        if (length_active !== 1'b0) begin errors++; $display("FAIL reset_active: got %0b want 0", length_active); end
        rst_n = 1;
        cyc();
        checks++;
        if (tri_out !== 4'hF) begin errors++; $display("FAIL release_tri: got %0h want f", tri_out); end
        timer_tick = 1;
        for (int i = 0; i < 20; i++) begin
            cyc();
            checks++;
            if (tri_out !== 4'hF || length_active !== 1'b0) begin
                errors++; $display("FAIL frozen_after_reset: cyc %0d tri=%0h act=%0b want f/0", i, tri_out, length_active);
            end
        end
        timer_tick = 0;
    endtask

    task automatic test_ramp();
        int changes;
        logic [SEQ_BITS-2:0] prev;
        channel_en = 1; length_select = 5'd1; linear_preset = 7'h10; linear_control = 0;
        wr_period_hi = 1; cyc(); wr_period_hi = 0;
        enable_240hz = 1; cyc(); enable_240hz = 0;
        checks++;
        if (length_active !== 1'b1) begin errors++; $display("FAIL load_active: got %0b want 1", length_active); end
        period = 11'h010; timer_tick = 1;
        changes = 0; prev = tri_out;
        for (int i = 0; i < 600; i++) begin
            cyc();
            checks++;
            if (tri_out !== m_tri[SEQ_BITS-2:0]) begin
                errors++; $display("FAIL ramp: cyc %0d got %0h want %0h", i, tri_out, m_tri);
            end
            if (tri_out !== prev) changes++;
            prev = tri_out;
        end
        // 600 cycles at 17 clk per step: 35 steps, of which one repeats a value at each end.
        checks++;
        if (changes < 30 || changes > 36) begin errors++; $display("FAIL ramp_rate: got %0d changes want ~33", changes); end
    endtask

    task automatic test_length_expire();
        logic [SEQ_BITS-2:0] held;
        length_select = 5'd3; linear_control = 0;
        wr_period_hi = 1; cyc(); wr_period_hi = 0;
        enable_120hz = 1; cyc(); enable_120hz = 0;
        checks++;
        if (length_active !== 1'b1) begin errors++; $display("FAIL len_1: got %0b want 1", length_active); end
        enable_120hz = 1; cyc(); enable_120hz = 0;
        checks++;
        if (length_active !== 1'b0) begin errors++; $display("FAIL len_0: got %0b want 0", length_active); end
        cyc();
        held = tri_out;
        for (int i = 0; i < 60; i++) begin
            cyc();
            checks++;
            if (tri_out !== held || tri_out !== m_tri[SEQ_BITS-2:0]) begin
                errors++; $display("FAIL len_freeze: cyc %0d got %0h want %0h", i, tri_out, held);
            end
        end
    endtask

    task automatic test_linear(input bit ctrl);
        int changes;
        logic [SEQ_BITS-2:0] prev;
        channel_en = 1; length_select = 5'd1; linear_preset = 7'd5; linear_control = ctrl;
        period = 11'd2; timer_tick = 1;
        wr_period_hi = 1; cyc(); wr_period_hi = 0;
        for (int s = 0; s < 7; s++) begin
            enable_240hz = 1; cyc(); enable_240hz = 0;
            for (int i = 0; i < 3 + int'($urandom_range(0, 3)); i++) begin
                cyc();
                checks++;
                if (tri_out !== m_tri[SEQ_BITS-2:0]) begin
                    errors++; $display("FAIL linear_ctrl%0d: strobe %0d got %0h want %0h", ctrl, s, tri_out, m_tri);
                end
            end
        end
        cyc(); cyc();
        changes = 0; prev = tri_out;
        for (int i = 0; i < 30; i++) begin
            cyc();
            if (tri_out !== prev) changes++;
            prev = tri_out;
        end
        checks++;
        if (ctrl && changes == 0) begin errors++; $display("FAIL linear_hold: got 0 changes want >0"); end
        else if (!ctrl && changes != 0) begin errors++; $display("FAIL linear_expire: got %0d changes want 0", changes); end
    endtask

    task automatic test_back_to_back();
        channel_en = 1; linear_control = 0; timer_tick = 0; length_select = 5'd30;
        wr_period_hi = 1; enable_120hz = 1; enable_240hz = 1; cyc();
        wr_period_hi = 0; enable_120hz = 0; enable_240hz = 0;
        for (int i = 0; i < 31; i++) begin
            enable_120hz = 1; cyc(); enable_120hz = 0; cyc();
        end
        checks++;
        if (length_active !== 1'b1) begin errors++; $display("FAIL load_beats_dec: got %0b want 1 after 31 decs", length_active); end
        enable_120hz = 1; cyc(); enable_120hz = 0;
        checks++;
        if (length_active !== 1'b0) begin errors++; $display("FAIL load_count: got %0b want 0 after 32 decs", length_active); end
    endtask

    task automatic test_channel_disable();
        channel_en = 1; length_select = 5'd1;
        wr_period_hi = 1; cyc(); wr_period_hi = 0;
        channel_en = 0; cyc();
        checks++;
        if (length_active !== 1'b0) begin errors++; $display("FAIL disable: got %0b want 0", length_active); end
        wr_period_hi = 1; cyc(); wr_period_hi = 0; cyc();
        checks++;
        if (length_active !== 1'b0) begin errors++; $display("FAIL disabled_write: got %0b want 0", length_active); end
        channel_en = 1;
    endtask

    task automatic test_ultrasonic();
        int changes;
        logic [SEQ_BITS-2:0] prev;
        channel_en = 1; length_select = 5'd1; linear_preset = 7'h40; linear_control = 1;
        wr_period_hi = 1; cyc(); wr_period_hi = 0;
        enable_240hz = 1; cyc(); enable_240hz = 0;
        period = 11'd1; timer_tick = 1;
        cyc();
        changes = 0; prev = tri_out;
        for (int i = 0; i < 40; i++) begin
            cyc();
            checks++;
            if (tri_out !== m_tri[SEQ_BITS-2:0]) begin
                errors++; $display("FAIL ultrasonic: cyc %0d got %0h want %0h", i, tri_out, m_tri);
            end
            if (tri_out !== prev) changes++;
            prev = tri_out;
        end
        checks++;
`ifdef ULTRASONIC_MUTE_EN
        if (changes != 0 || tri_out !== MID[SEQ_BITS-2:0]) begin
            errors++; $display("FAIL mute_level: got %0h (%0d changes) want %0h constant", tri_out, changes, MID);
        end
`else
        if (changes == 0) begin errors++; $display("FAIL no_mute: got 0 changes want ramp"); end
`endif
        linear_control = 0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            rst_n          = ($urandom % 300) != 0;
            timer_tick     = ($urandom % 4) != 0;
            enable_240hz   = ($urandom % 12) == 0;
            enable_120hz   = ($urandom % 12) == 0;
            channel_en     = ($urandom % 60) != 0;
            linear_control = ($urandom % 4) == 0;
            linear_preset  = LIN_W'($urandom_range(0, 2 ** LIN_W - 1));
            period         = TIMER_W'($urandom_range(0, 7));
            length_select  = 5'($urandom_range(0, 31));
            wr_period_hi   = ($urandom % 25) == 0;
            cyc();
            checks++;
            if (tri_out !== m_tri[SEQ_BITS-2:0] || length_active !== m_act[0]) begin
                errors++; $display("FAIL random: cyc %0d tri=%0h act=%0b want %0h/%0b", i, tri_out, length_active, m_tri, m_act);
            end
        end
        rst_n = 1; idle_inputs();
    endtask

    initial begin
        m_timer = 0; m_seq = 0; m_lin = 0; m_len = 0; m_flag = 0; m_tri = 0; m_act = 0;
        test_reset();
        test_ramp();
        test_length_expire();
        test_linear(1'b1);
        test_linear(1'b0);
        test_back_to_back();
        test_channel_disable();
        test_ultrasonic();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
